load_store_unit: RTL

- Initiator side of the data-memory port: accepts one load or store request at a time from the processor datapath.
- Sequences the memory control lines C_DMRead/C_DMWrite, address and write data with guaranteed mutual exclusion.
- Returns load data with a one-cycle valid pulse.
- Sits between the execute/memory stage and dataMemory; the memory itself is unchanged.

---
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Data-memory initiator: sequences one load or store at a time onto dataMemory.
// Optional BYTE_ACCESS_EN adds byte loads and read-modify-write byte stores.
module load_store_unit #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              C_Req,
    output logic              C_Ready,
    input  logic              C_IsStore,
    input  logic              C_Byte,
    input  logic              C_ByteSel,
    input  logic [ADDR_W-1:0] A_Addr,
    input  logic [DATA_W-1:0] D_StoreData,
    output logic [DATA_W-1:0] D_LoadData,
    output logic              C_LoadValid,
    output logic [ADDR_W-1:0] A_DataAddress,
    output logic [DATA_W-1:0] D_WriteData,
    output logic              C_DMRead,
    output logic              C_DMWrite,
    input  logic [DATA_W-1:0] D_Data
);

    typedef enum logic [2:0] {
`ifdef BYTE_ACCESS_EN
        RMW_READ,
        RMW_WRITE,
`endif
        IDLE,
        READ,
        WRITE
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ready_d, valid_d, rd_d, wr_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d, ldata_d, load_word;

`ifdef BYTE_ACCESS_EN
    logic                byte_q, byte_d;
    logic                sel_q, sel_d;
    logic [7:0]          sdata_q, sdata_d;
    logic                unused_hi;

    assign unused_hi = ^D_StoreData[DATA_W-1:8];
    assign load_word = !byte_q ? D_Data :
                       sel_q   ? {{(DATA_W-8){1'b0}}, D_Data[15:8]} :
                                 {{(DATA_W-8){1'b0}}, D_Data[7:0]};
`else
    logic                unused_byte;

    assign unused_byte = C_Byte ^ C_ByteSel;
    assign load_word   = D_Data;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = C_Ready;
        valid_d = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = A_DataAddress;
        wdata_d = D_WriteData;
        ldata_d = D_LoadData;
`ifdef BYTE_ACCESS_EN
        byte_d  = byte_q;
        sel_d   = sel_q;
        sdata_d = sdata_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (C_Req) begin
                    addr_d  = A_Addr;
                    ready_d = 1'b0;
                    cnt_d   = LAT_M1;
`ifdef BYTE_ACCESS_EN
                    byte_d  = C_Byte;
                    sel_d   = C_ByteSel;
                    sdata_d = D_StoreData[7:0];
                    if (C_IsStore && C_Byte) begin
                        state_d = RMW_READ;
                        rd_d    = 1'b1;
                    end else
`endif
                    if (C_IsStore) begin
                        state_d = WRITE;
                        wr_d    = 1'b1;
                        wdata_d = D_StoreData;
                    end else begin
                        state_d = READ;
                        rd_d    = 1'b1;
                    end
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    valid_d = 1'b1;
                    ldata_d = load_word;
                end else begin
                    rd_d  = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
`ifdef BYTE_ACCESS_EN
            RMW_READ: begin
                if (cnt_q == 4'd0) begin
                    // merge the new byte into the word just read
                    state_d = RMW_WRITE;
                    wr_d    = 1'b1;
                    wdata_d = sel_q ? {sdata_q, D_Data[7:0]}
                                    : {D_Data[15:8], sdata_q};
                end else begin
                    rd_d  = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RMW_WRITE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            C_Ready       <= 1'b1;
            C_LoadValid   <= 1'b0;
            C_DMRead      <= 1'b0;
            C_DMWrite     <= 1'b0;
            A_DataAddress <= '0;
            D_WriteData   <= '0;
            D_LoadData    <= '0;
`ifdef BYTE_ACCESS_EN
            byte_q        <= 1'b0;
            sel_q         <= 1'b0;
            sdata_q       <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            C_Ready       <= ready_d;
            C_LoadValid   <= valid_d;
            C_DMRead      <= rd_d;
            C_DMWrite     <= wr_d;
            A_DataAddress <= addr_d;
            D_WriteData   <= wdata_d;
            D_LoadData    <= ldata_d;
`ifdef BYTE_ACCESS_EN
            byte_q        <= byte_d;
            sel_q         <= sel_d;
            sdata_q       <= sdata_d;
`endif
        end
    end

endmodule
